fpu_cmd_seq: RTL and testbench
==============================

Name: fpu_cmd_seq

Overview:
- Upstream command sequencer for the FPU core. It sits between the ESP32 byte link (UART/SPI byte receiver and transmitter) and the FPU.
- Assembles a 9-byte command frame into opcode and operands, then presents them to the FPU with stable values.
- Waits the FPU's registered latency, captures the result and streams a 5-byte response back to the host.

Parameters:
- FPU_LAT, 2: clk cycles between the operands/op being stable at the FPU and fpu_s being valid (min 1).
- TIMEOUT, 50000: idle cycles allowed between bytes of a partial frame before the frame is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous to clk, active-high
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts rx_data this cycle
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data this cycle
- fpu_a  out  32  operand A to FPU (IEEE-754 single)
- fpu_b  out  32  operand B to FPU
- fpu_zt  out  2  FPU op select: 01 add, 10 sub, 11 mul, 00 div
- fpu_s  in  32  FPU result
- busy  out  1  high whenever state is not IDLE
- err_count  out  8  count of bad-opcode and timed-out frames, saturates at 255

Behaviour:
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, fpu_a=0, fpu_b=0, fpu_zt=2'b01, busy=0, err_count=0. rst in any state forces IDLE on the next edge; any partial frame or response in flight is dropped.
- Handshakes: a byte transfers when valid&&ready at a rising edge. tx_data and tx_valid stay stable until accepted.
- Frame format: byte0 = opcode; bytes1-4 = A, MSB first; bytes5-8 = B, MSB first. A frame is always 9 bytes, regardless of opcode.
- Opcode mapping: 0x01 add, 0x02 sub, 0x03 mul, 0x04 div. fpu_zt = opcode[1:0], so 0x04 gives 00. Any other value is a bad opcode.
- State IDLE: rx_ready=1. Byte accepted -> latch opcode, byte index=1, go to RX.
- State RX: rx_ready=1. Each accepted byte shifts into the A/B shift register and increments the index. On the 9th byte:
  - valid opcode -> EXEC;
  - bad opcode -> RESP with status 0x01 and result 0x00000000, err_count+1.
- RX timeout: the idle counter resets on each accepted byte. When it reaches TIMEOUT, the frame is discarded, err_count+1, and the state goes to IDLE.
- State EXEC: rx_ready=0. fpu_a, fpu_b and fpu_zt are driven from the latched frame and held until the next frame reaches EXEC. A wait counter loads FPU_LAT-1 and decrements once per cycle; at 0, state goes to CAP.
- State CAP: one cycle; result register <= fpu_s, status = 0x00; then RESP.
  - Net latency: 9th byte accepted -> fpu inputs change next edge -> fpu_s sampled exactly FPU_LAT+1 cycles after that edge.
- State RESP: rx_ready=0. Sends 5 bytes: status, then result[31:24], [23:16], [15:8], [7:0]. The first byte has tx_valid=1 on the cycle after entry. After the 5th is accepted, go to IDLE; rx_ready=1 the following cycle.
- tx_ready held low: the block stalls in RESP indefinitely. There is no timeout in RESP.
- rx bytes arriving while the block is not ready are not accepted; upstream must hold them (valid/ready rule).
- err_count holds at 255 with no wrap.
- The block performs no floating-point arithmetic and passes fpu_s bit-exact.

Test Plan:
- Add: frame 01 3F C0 00 00 40 10 00 00 (1.5+2.25) -> fpu_zt=01, fpu_a=0x3FC00000, fpu_b=0x40100000; response 00 40 70 00 00.
- Mul and div back-to-back:
  - 03 40 00 00 00 40 40 00 00 (2×3) -> 00 40 C0 00 00;
  - then 04 40 C0 00 00 40 00 00 00 -> fpu_zt=00, response 00 40 40 00 00.
- Bad opcode: 07 followed by 8 arbitrary bytes -> response 01 00 00 00 00, err_count 0->1, fpu_* unchanged from the previous frame.
- Timeout: TIMEOUT=16; send 4 bytes, then idle 16 cycles -> IDLE, err_count+1, no tx_valid. A following valid add frame is answered correctly.
- Backpressure/reset:
  - tx_ready=0 for 20 cycles mid-response -> tx_data stable and byte order intact;
  - separately, assert rst during RX at byte 5 -> all outputs at reset values next cycle, and the next full frame is processed normally.

Source files
------------

// File: rtl/fpu_cmd_seq_if.sv
// Byte-link and FPU-side signal bundle for the FPU command sequencer.
// The slave view belongs to the sequencer. The master view belongs to the host/FPU side.
interface fpu_cmd_seq_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [1:0]  fpu_zt;
  logic [31:0] fpu_s;

  modport slave (
    input  rx_data, rx_valid, tx_ready, fpu_s,
    output rx_ready, tx_data, tx_valid, fpu_a, fpu_b, fpu_zt
  );

  modport master (
    output rx_data, rx_valid, tx_ready, fpu_s,
    input  rx_ready, tx_data, tx_valid, fpu_a, fpu_b, fpu_zt
  );
endinterface

// File: rtl/fpu_cmd_seq.sv
// Receives a 9-byte command frame and drives the FPU with stable operands.
// After waiting out the FPU latency, it streams a 5-byte status/result response.
module fpu_cmd_seq #(
  parameter int unsigned FPU_LAT = 2,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic         clk,
  input  logic         rst,
  fpu_cmd_seq_if.slave bus,
  output logic         busy,
  output logic [7:0]   err_count
);

  localparam int unsigned WAIT_W = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_EXEC,
    S_CAP,
    S_RESP
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic               r_rx_ready;
  logic               r_tx_valid;
  logic [7:0]         r_tx_data;
  logic [31:0]        r_fpu_a;
  logic [31:0]        r_fpu_b;
  logic [1:0]         r_fpu_zt;
  logic [7:0]         r_err_count;
  logic [7:0]         r_opcode;
  logic [55:0]        r_shift;
  logic [3:0]         r_idx;
  logic [TO_W-1:0]    r_idle_cnt;
  logic [WAIT_W-1:0]  r_wait;
  logic [31:0]        r_result;
  logic [2:0]         r_tx_idx;

  logic               w_rx_fire;
  logic               w_tx_fire;
  logic               w_op_ok;
  logic               w_last;
  logic               w_timeout;
  logic               w_err_inc;

  assign w_rx_fire = bus.rx_valid && r_rx_ready;
  assign w_tx_fire = r_tx_valid && bus.tx_ready;
  assign w_op_ok   = (r_opcode >= 8'h01) && (r_opcode <= 8'h04);
  assign w_last    = (r_state == S_RX) && w_rx_fire && (r_idx == 4'd8);
  assign w_timeout = (r_state == S_RX) && !w_rx_fire &&
                     (r_idle_cnt == TO_W'(TIMEOUT - 1));
  assign w_err_inc = w_timeout || (w_last && !w_op_ok);

  // NOTE: next state gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_rx_fire) w_next = S_RX;
      S_RX: begin
        if (w_last)         w_next = w_op_ok ? S_EXEC : S_RESP;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_EXEC: if (r_wait == '0) w_next = S_CAP;
      S_CAP:  w_next = S_RESP;
      S_RESP: if (w_tx_fire && (r_tx_idx == 3'd4)) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: every register uses non-blocking assignment so all update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_ready  <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_fpu_a     <= 32'h0;
      r_fpu_b     <= 32'h0;
      r_fpu_zt    <= 2'b01;
      r_err_count <= 8'h00;
      r_opcode    <= 8'h00;
      r_shift     <= '0;
      r_idx       <= 4'd0;
      r_idle_cnt  <= '0;
      r_wait      <= '0;
      r_result    <= 32'h0;
      r_tx_idx    <= 3'd0;
    end else begin
      // Registered ready follows the state being entered, so it is clean out of reset.
      r_rx_ready <= (w_next == S_IDLE) || (w_next == S_RX);

      case (r_state)
        S_IDLE: begin
          if (w_rx_fire) begin
            r_opcode   <= bus.rx_data;
            r_idx      <= 4'd1;
            r_idle_cnt <= '0;
          end
        end
        S_RX: begin
          if (w_rx_fire) begin
            r_shift    <= {r_shift[47:0], bus.rx_data};
            r_idx      <= r_idx + 1'b1;
            r_idle_cnt <= '0;
            if (r_idx == 4'd8) begin
              if (w_op_ok) begin
                r_fpu_a  <= r_shift[55:24];
                r_fpu_b  <= {r_shift[23:0], bus.rx_data};
                r_fpu_zt <= r_opcode[1:0];
                r_wait   <= WAIT_W'(FPU_LAT - 1);
              end else begin
                r_result   <= 32'h0;
                r_tx_data  <= 8'h01;
                r_tx_valid <= 1'b1;
                r_tx_idx   <= 3'd0;
              end
            end
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          if (r_wait != '0) r_wait <= r_wait - 1'b1;
        end
        S_CAP: begin
          r_result   <= bus.fpu_s;
          r_tx_data  <= 8'h00;
          r_tx_valid <= 1'b1;
          r_tx_idx   <= 3'd0;
        end
        S_RESP: begin
          // Result bytes leave MSB first by shifting the captured word up.
          if (w_tx_fire) begin
            r_tx_idx <= r_tx_idx + 1'b1;
            if (r_tx_idx == 3'd4) begin
              r_tx_valid <= 1'b0;
            end else begin
              r_tx_data <= r_result[31:24];
              r_result  <= {r_result[23:0], 8'h00};
            end
          end
        end
        default: ;
      endcase

      if (w_err_inc && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 1'b1;
    end
  end

  assign bus.rx_ready = r_rx_ready;
  assign bus.tx_valid = r_tx_valid;
  assign bus.tx_data  = r_tx_data;
  assign bus.fpu_a    = r_fpu_a;
  assign bus.fpu_b    = r_fpu_b;
  assign bus.fpu_zt   = r_fpu_zt;
  assign busy         = (r_state != S_IDLE);
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_fpu_cmd_seq.sv
// Scoreboard bench for fpu_cmd_seq: frames are issued and their expected response bytes are queued.
// An independent tx monitor pops and compares the queued bytes; a latency-accurate FPU stub supplies fpu_s.
module tb_fpu_cmd_seq;

  localparam int FPU_LAT = 2;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy;
  logic [7:0] err_count;

  fpu_cmd_seq_if bus();

  fpu_cmd_seq #(.FPU_LAT(FPU_LAT), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  int          tx_mode  = 2;   // 0 random ready, 1 ready low, 2 ready high
  int          n_popped = 0;
  logic [31:0] m_a  = 32'h0;
  logic [31:0] m_b  = 32'h0;
  logic [1:0]  m_zt = 2'b01;
  int          m_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // FPU stand-in: the three test-plan vectors give IEEE results, and all other inputs are hashed.
  function automatic logic [31:0] fpu_ref(input logic [1:0] zt, input logic [31:0] a,
                                          input logic [31:0] b);
    if (zt == 2'b01 && a == 32'h3FC00000 && b == 32'h40100000) return 32'h40700000;
    if (zt == 2'b11 && a == 32'h40000000 && b == 32'h40400000) return 32'h40C00000;
    if (zt == 2'b00 && a == 32'h40C00000 && b == 32'h40000000) return 32'h40400000;
    return (a + {b[7:0], b[31:8]}) ^ {zt, 30'h0ABC1234};
  endfunction

  logic [31:0] fpu_pipe [FPU_LAT];
  always @(posedge clk) begin
    fpu_pipe[0] <= fpu_ref(bus.fpu_zt, bus.fpu_a, bus.fpu_b);
    for (int k = 1; k < FPU_LAT; k++) fpu_pipe[k] <= fpu_pipe[k-1];
  end
  assign bus.fpu_s = fpu_pipe[FPU_LAT-1];

  always @(posedge clk) begin
    #1;
    case (tx_mode)
      0:       bus.tx_ready = ($urandom_range(0, 3) != 0);
      1:       bus.tx_ready = 1'b0;
      default: bus.tx_ready = 1'b1;
    endcase
  end

  // Monitor: sampled on the falling edge, so valid&&ready here means a transfer at the next rise.
  logic       pend      = 1'b0;
  logic [7:0] pend_data = 8'h00;
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
        check("tx_hold_data", 32'(bus.tx_data), 32'(pend_data));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected: got byte %h, expected no response byte at %0t",
                   bus.tx_data, $time);
        end else begin
          check("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
        n_popped++;
      end
      pend      = bus.tx_valid && !bus.tx_ready;
      pend_data = bus.tx_data;
    end
  end

  // Caller is positioned just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   t;
    acc = 1'b0;
    t   = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = bus.rx_ready;
      @(posedge clk);
      #1;
      t++;
      if (!acc && t > 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_accept_timeout: byte %h never accepted, expected acceptance", b);
        acc = 1'b1;
      end
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic issue_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                             input int gap_max);
    logic [71:0] f;
    logic [31:0] r;
    f = {op, a, b};
    if (op >= 8'h01 && op <= 8'h04) begin
      r = fpu_ref(op[1:0], a, b);
      exp_q.push_back(8'h00);
      exp_q.push_back(r[31:24]);
      exp_q.push_back(r[23:16]);
      exp_q.push_back(r[15:8]);
      exp_q.push_back(r[7:0]);
      m_a  = a;
      m_b  = b;
      m_zt = op[1:0];
    end else begin
      exp_q.push_back(8'h01);
      repeat (4) exp_q.push_back(8'h00);
      if (m_err < 255) m_err++;
    end
    for (int i = 0; i < 9; i++) begin
      send_byte(f[71-8*i -: 8]);
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic finish_frame(input string tag);
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && !busy) && t <= 3000) begin
      @(negedge clk);
      t++;
    end
    if (t > 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_done_timeout: response incomplete, %0d bytes still expected",
               tag, exp_q.size());
    end
    check({tag, "_fpu_a"}, bus.fpu_a, m_a);
    check({tag, "_fpu_b"}, bus.fpu_b, m_b);
    check({tag, "_fpu_zt"}, 32'(bus.fpu_zt), 32'(m_zt));
    check({tag, "_err_count"}, 32'(err_count), 32'(m_err));
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_fpu_a"}, bus.fpu_a, 32'd0);
    check({tag, "_fpu_b"}, bus.fpu_b, 32'd0);
    check({tag, "_fpu_zt"}, 32'(bus.fpu_zt), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int t;
    logic [7:0] op;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("init");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed add, then mul and div back to back.
    issue_frame(8'h01, 32'h3FC00000, 32'h40100000, 0);
    finish_frame("add");
    issue_frame(8'h03, 32'h40000000, 32'h40400000, 0);
    finish_frame("mul");
    issue_frame(8'h04, 32'h40C00000, 32'h40000000, 0);
    finish_frame("div");

    // A bad opcode leaves the FPU-side registers unchanged.
    issue_frame(8'h07, $urandom, $urandom, 0);
    finish_frame("badop");

    // Timeout: four bytes, then silence.
    tx_mode = 0;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    if (m_err < 255) m_err++;
    repeat (TIMEOUT) @(posedge clk);
    @(negedge clk);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_err_count", 32'(err_count), 32'(m_err));
    check("timeout_tx_valid", 32'(bus.tx_valid), 32'd0);
    @(posedge clk);
    #1;
    issue_frame(8'h01, 32'h3FC00000, 32'h40100000, 0);
    finish_frame("post_timeout_add");

    // Backpressure: stall the transmitter mid-response for 20 cycles.
    tx_mode = 2;
    base = n_popped;
    issue_frame(8'h02, 32'h12345678, 32'h9ABCDEF0, 0);
    t = 0;
    while (n_popped < base + 2 && t < 2000) begin @(negedge clk); t++; end
    check("stall_reached_mid_response", 32'(n_popped - base), 32'd2);
    tx_mode = 1;
    repeat (20) @(posedge clk);
    #1;
    tx_mode = 0;
    finish_frame("stall");

    // Reset during RX after byte 5.
    send_byte(8'h01);
    for (int i = 0; i < 4; i++) send_byte(8'($urandom));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset("midrx");
    rst  = 1'b0;
    m_a  = 32'h0;
    m_b  = 32'h0;
    m_zt = 2'b01;
    m_err = 0;
    @(posedge clk);
    #1;
    issue_frame(8'h03, 32'h40000000, 32'h40400000, 0);
    finish_frame("post_reset_mul");

    // Randomized frames with random gaps and random transmitter readiness.
    tx_mode = 0;
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) op = 8'($urandom);
      else                           op = 8'($urandom_range(1, 4));
      issue_frame(op, $urandom, $urandom, 3);
      finish_frame("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
